// File: rtl/totp_fob_core.sv
// totp_fob_core: single-clock 2FA key-fob core. Tick/step timebase, keyed hash,
// iterative double-dabble BCD converter, debounced button and display window FSM.
// Optional build macro FOB_BLANK_LEADING_EN blanks leading zero digits while shown.
module totp_fob_core #(
    parameter int unsigned W              = 16,
    parameter int unsigned DIGITS         = 5,
    parameter int unsigned TICK_DIV       = 1000,
    parameter int unsigned STEP_TICKS     = 5000,
    parameter int unsigned DEBOUNCE_TICKS = 10,
    parameter int unsigned SHOW_TICKS     = 3000
) (
    input  logic                sysclk,
    input  logic                rst_n,
    input  logic                button_in,
    input  logic [W-1:0]        student_id,
    output logic [4*DIGITS-1:0] digits,
    output logic                display_on,
    output logic                code_valid,
    output logic [W-1:0]        cur_time
);

    localparam int unsigned BW      = 4 * DIGITS;
    localparam int unsigned TCW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SCW     = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam int unsigned ICW     = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned CNT_MAX = (SHOW_TICKS > DEBOUNCE_TICKS) ? SHOW_TICKS : DEBOUNCE_TICKS;
    localparam int unsigned BCW     = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {StIdle, StDeb, StShow, StHold} state_t;

    logic [TCW-1:0]  r_tick_cnt;
    logic [SCW-1:0]  r_step_cnt;
    logic [W-1:0]    r_cur_time;
    logic            r_started;
    logic            r_load;
    logic [W-1:0]    r_bin;
    logic [BW-1:0]   r_bcd;
    logic [ICW-1:0]  r_bit;
    logic            r_busy;
    logic            r_done;
    logic [BW-1:0]   r_code;
    logic            r_code_valid;
    logic            r_sync1;
    logic            r_sync2;
    state_t          r_state;
    state_t          w_state_d;
    logic [BCW-1:0]  r_btn_cnt;
    logic [BCW-1:0]  w_btn_cnt_d;

    logic            w_tick;
    logic            w_step_wrap;
    logic [W-1:0]    w_x;
    logic [W-1:0]    w_mul;
    logic [W-1:0]    w_hash;
    logic [BW-1:0]   w_bcd_adj;
    logic [BW+W-1:0] w_shift;

    assign w_tick      = (r_tick_cnt == TCW'(TICK_DIV - 1));
    assign w_step_wrap = w_tick && (r_step_cnt == SCW'(STEP_TICKS - 1));

    // Hash uses the already-incremented time because the load is one cycle behind the step.
    assign w_x    = r_cur_time ^ student_id;
    assign w_mul  = w_x * W'(16'h9E37);
    assign w_hash = w_mul ^ {w_x[W/2-1:0], w_x[W-1:W/2]};

    // Timebase: tick divider, step counter, current time and load requests.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_step_cnt <= '0;
            r_cur_time <= '0;
            r_started  <= 1'b0;
            r_load     <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
                r_step_cnt <= w_step_wrap ? '0 : r_step_cnt + 1'b1;
            end
            if (w_step_wrap) begin
                r_cur_time <= r_cur_time + 1'b1;
            end
            r_started <= 1'b1;
            r_load    <= !r_started || w_step_wrap;
        end
    end

    // Double-dabble step: add 3 to every digit >= 5, then shift one binary bit in.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_bcd[4*i+:4] >= 4'd5) begin
                w_bcd_adj[4*i+:4] = r_bcd[4*i+:4] + 4'd3;
            end
        end
        w_shift = {w_bcd_adj, r_bin} << 1;
    end

    // Converter: a load captures the hash and (re)starts; W shifts later r_done pulses.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_bit  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (r_load) begin
            r_bin  <= w_hash;
            r_bcd  <= '0;
            r_bit  <= '0;
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_bcd  <= w_shift[BW+W-1:W];
            r_bin  <= w_shift[W-1:0];
            r_bit  <= r_bit + 1'b1;
            r_busy <= (r_bit != ICW'(W - 1));
            r_done <= (r_bit == ICW'(W - 1));
        end else begin
            r_done <= 1'b0;
        end
    end

    // Atomic copy of a finished conversion into the displayed code.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_code       <= '0;
            r_code_valid <= 1'b0;
        end else if (r_done) begin
            r_code       <= r_bcd;
            r_code_valid <= 1'b1;
        end
    end

    // Button synchroniser and FSM state/counter registers.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= StIdle;
            r_btn_cnt <= '0;
        end else begin
            r_sync1   <= button_in;
            r_sync2   <= r_sync1;
            r_state   <= w_state_d;
            r_btn_cnt <= w_btn_cnt_d;
        end
    end

    // Debounce / display-window next state; counter only moves on tick.
    always_comb begin
        w_state_d   = r_state;
        w_btn_cnt_d = r_btn_cnt;
        unique case (r_state)
            StIdle: begin
                if (r_sync2) begin
                    w_state_d   = StDeb;
                    w_btn_cnt_d = '0;
                end
            end
            StDeb: begin
                if (!r_sync2) begin
                    w_state_d = StIdle;
                end else if (w_tick) begin
                    if (r_btn_cnt == BCW'(DEBOUNCE_TICKS - 1)) begin
                        w_state_d   = StShow;
                        w_btn_cnt_d = BCW'(SHOW_TICKS);
                    end else begin
                        w_btn_cnt_d = r_btn_cnt + 1'b1;
                    end
                end
            end
            StShow: begin
                if (w_tick) begin
                    w_btn_cnt_d = (r_btn_cnt == '0) ? '0 : r_btn_cnt - 1'b1;
                    if (r_btn_cnt <= BCW'(1)) begin
                        w_state_d = r_sync2 ? StHold : StIdle;
                    end
                end
            end
            StHold: begin
                if (!r_sync2) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign display_on = (r_state == StShow);
    assign code_valid = r_code_valid;
    assign cur_time   = r_cur_time;

`ifdef FOB_BLANK_LEADING_EN
    logic w_lead;
`endif

    // Digit output: blank outside the window or before the first code.
    always_comb begin
        digits = '1;
`ifdef FOB_BLANK_LEADING_EN
        w_lead = 1'b1;
        if (display_on && code_valid) begin
            for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
                if (w_lead && (r_code[4*i+:4] == 4'd0)) begin
                    digits[4*i+:4] = 4'hF;
                end else begin
                    w_lead         = 1'b0;
                    digits[4*i+:4] = r_code[4*i+:4];
                end
            end
            digits[3:0] = r_code[3:0];
        end
`else
        if (display_on && code_valid) begin
            digits = r_code;
        end
`endif
    end

endmodule

// File: tb/tb_totp_fob_core.sv
// Directed self-checking bench for totp_fob_core with small timebase parameters.
module tb_totp_fob_core;

    logic        sysclk     = 1'b0;
    logic        rst_n      = 1'b0;
    logic        button_in  = 1'b0;
    logic [15:0] student_id = 16'h0001;
    logic [19:0] digits;
    logic        display_on;
    logic        code_valid;
    logic [15:0] cur_time;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    totp_fob_core #(
        .W              (16),
        .DIGITS         (5),
        .TICK_DIV       (4),
        .STEP_TICKS     (5),
        .DEBOUNCE_TICKS (2),
        .SHOW_TICKS     (8)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .button_in  (button_in),
        .student_id (student_id),
        .digits     (digits),
        .display_on (display_on),
        .code_valid (code_valid),
        .cur_time   (cur_time)
    );

    always #5 sysclk = ~sysclk;

    // cyc == k+1 after the k-th edge (0-based) since reset release.
    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic at_edge(input int k);
        do begin
            @(posedge sysclk);
            #1;
        end while (cyc < k + 1);
    endtask

    logic [19:0] zero_code;
    logic        any_on;
    int          lat;
    logic        found;

    initial begin
`ifdef FOB_BLANK_LEADING_EN
        zero_code = 20'hFFFF0;
`else
        zero_code = 20'h00000;
`endif
        // Reset state
        #22;
        chk("rst_digits", 32'(digits), 32'hFFFFF);
        chk("rst_display", 32'(display_on), 32'd0);
        chk("rst_valid", 32'(code_valid), 32'd0);
        chk("rst_time", 32'(cur_time), 32'd0);
        @(negedge sysclk);
        rst_n = 1'b1;

        // Reset release: first code lands 18 cycles after the first edge
        at_edge(17);
        chk("valid_e17", 32'(code_valid), 32'd0);
        at_edge(18);
        chk("valid_e18", 32'(code_valid), 32'd1);
        chk("code_e18", 32'(dut.r_code), 32'h40759);
        chk("digits_e18", 32'(digits), 32'hFFFFF);
        chk("display_e18", 32'(display_on), 32'd0);
        chk("time_e18", 32'(cur_time), 32'd0);
        button_in = 1'b1;

        at_edge(19);
        chk("time_e19", 32'(cur_time), 32'd1);

        // Valid press: sync at 20, DEB at 21, ticks at 23 and 27
        at_edge(26);
        chk("display_e26", 32'(display_on), 32'd0);
        at_edge(27);
        chk("display_e27", 32'(display_on), 32'd1);
        chk("digits_e27", 32'(digits), 32'h40759);

        // Step rollover: x = 0 -> code 0 shown 18 cycles after increment at 19
        at_edge(36);
        chk("digits_e36", 32'(digits), 32'h40759);
        at_edge(37);
        chk("digits_e37", 32'(digits), 32'(zero_code));
        chk("time_e37", 32'(cur_time), 32'd1);

        // Next step (time 2, x=3): code 55717 replaces 0 inside the window
        at_edge(56);
        chk("digits_e56", 32'(digits), 32'(zero_code));
        at_edge(57);
        chk("digits_e57", 32'(digits), 32'h55717);

        // Window expires on the 8th tick after entry (edge 59)
        at_edge(58);
        chk("display_e58", 32'(display_on), 32'd1);
        at_edge(59);
        chk("display_e59", 32'(display_on), 32'd0);
        chk("digits_e59", 32'(digits), 32'hFFFFF);

        // Hold past window: no retrigger while the button stays down
        any_on = 1'b0;
        repeat (40) begin
            @(posedge sysclk);
            #1;
            if (display_on) any_on = 1'b1;
        end
        chk("hold_stays_off", 32'(any_on), 32'd0);

        // Release, then a glitch shorter than one tick
        button_in = 1'b0;
        repeat (10) @(posedge sysclk);
        #1;
        button_in = 1'b1;
        repeat (2) @(posedge sysclk);
        #1;
        button_in = 1'b0;
        any_on = 1'b0;
        repeat (30) begin
            @(posedge sysclk);
            #1;
            if (display_on) any_on = 1'b1;
        end
        chk("glitch_off", 32'(any_on), 32'd0);

        // Fresh press: 2 sync + 1 FSM cycle + 2 ticks, latency 8..11 edges
        button_in = 1'b1;
        lat = 0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge sysclk);
            #1;
            if (display_on) begin
                lat = i;
                break;
            end
        end
        chk("fresh_display", 32'(display_on), 32'd1);
        chk("fresh_latency", 32'((lat >= 8) && (lat <= 11)), 32'd1);

        // Reset in SHOW with a conversion in flight
        found = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (dut.r_busy) begin
                found = 1'b1;
                break;
            end
            @(posedge sysclk);
            #1;
        end
        chk("busy_seen", 32'(found), 32'd1);
        chk("show_before_rst", 32'(display_on), 32'd1);
        #2;
        rst_n     = 1'b0;
        button_in = 1'b0;
        #1;
        chk("mid_rst_digits", 32'(digits), 32'hFFFFF);
        chk("mid_rst_display", 32'(display_on), 32'd0);
        chk("mid_rst_valid", 32'(code_valid), 32'd0);
        chk("mid_rst_time", 32'(cur_time), 32'd0);
        chk("mid_rst_busy", 32'(dut.r_busy), 32'd0);
        @(negedge sysclk);
        rst_n = 1'b1;

        // Recovery matches the reset-release scenario
        at_edge(17);
        chk("rec_valid_e17", 32'(code_valid), 32'd0);
        at_edge(18);
        chk("rec_valid_e18", 32'(code_valid), 32'd1);
        chk("rec_code_e18", 32'(dut.r_code), 32'h40759);
        chk("rec_digits_e18", 32'(digits), 32'hFFFFF);
        chk("rec_display_e18", 32'(display_on), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
